// File: rtl/if_id_skid_buffer.sv
// IF/ID pipeline boundary: 2-entry skid buffer between fetch and decode.
// in_ready comes from registered occupancy only, so decode stalls never reach the PC combinationally.
module if_id_skid_buffer #(
   parameter int          XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] pc4_in,
   input  logic [31:0]     instruction_in,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc4_out,
   output logic [31:0]     instruction_out,
   output logic [1:0]      occupancy
);

   logic [XLEN-1:0] pc_q    [2];
   logic [XLEN-1:0] pc_d    [2];
   logic [XLEN-1:0] pc4_q   [2];
   logic [XLEN-1:0] pc4_d   [2];
   logic [31:0]     instr_q [2];
   logic [31:0]     instr_d [2];
   logic            head_q, head_d;
   logic            tail_q, tail_d;
   logic [1:0]      count_q, count_d;
   logic            push, pop;

   always_comb begin
      pc_d     = pc_q;
      pc4_d    = pc4_q;
      instr_d  = instr_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;

      in_ready  = (count_q != 2'd2);
      out_valid = (count_q != 2'd0);
      push      = in_valid & in_ready & ~flush;
      pop       = out_valid & out_ready;

      if (push) begin
         pc_d[tail_q]    = pc_in;
         pc4_d[tail_q]   = pc4_in;
         instr_d[tail_q] = instruction_in;
         tail_d          = ~tail_q;
      end
      if (pop)
         head_d = ~head_q;

      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      // A pop under flush still counts as consumed by decode; only the bookkeeping is reset.
      if (flush) begin
         head_d  = 1'b0;
         tail_d  = 1'b0;
         count_d = 2'd0;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < 2; i++) begin
            pc_q[i]    <= '0;
            pc4_q[i]   <= '0;
            instr_q[i] <= NOP_INSTR;
         end
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         instr_q <= instr_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Empty buffer presents a harmless NOP rather than stale data.
   always_comb begin
      occupancy = count_q;
      if (count_q != 2'd0) begin
         pc_out          = pc_q[head_q];
         pc4_out         = pc4_q[head_q];
         instruction_out = instr_q[head_q];
      end else begin
         pc_out          = '0;
         pc4_out         = '0;
         instruction_out = NOP_INSTR;
      end
   end

endmodule
